// File: rtl/audio_frame_pkg.sv
// Shared types and constants for the audio frame transmitter.
package audio_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_DATA,
    ST_SUM
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         FRAME_OVERHEAD = 3;

endpackage

// File: rtl/audio_frame_tx_if.sv
// Byte stream from the frame sender to the UART transmitter.
interface audio_frame_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_buf_ram.sv
// Simple dual-port sample buffer with synchronous read; one block RAM.
module frame_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/audio_frame_tx.sv
// Ping-pong sample capture and framed UART streaming: sync, count, samples, XOR sum.
// state | meaning: IDLE wait for full bank | HDR sync byte | CNT frame count | DATA samples | SUM checksum
module audio_frame_tx
  import audio_frame_pkg::*;
#(
  parameter int         BUF_LEN   = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  audio_frame_tx_if.master tx,
  output logic [7:0]       frame_count,
  output logic             overrun
);

  localparam int ADDR_W = $clog2(BUF_LEN);

  logic [1:0]        bank_full_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic              overrun_q;
  logic [7:0]        frame_count_q;
  tx_state_e         state_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic              rd_last_q;
  logic [7:0]        checksum_q;
  logic [7:0]        tx_byte_q;
  logic              tx_valid_q;

  logic              fire;
  logic              wr_en;
  logic              ld_data;
  logic [ADDR_W-1:0] rd_idx_d;
  logic [ADDR_W:0]   rd_addr;
  logic [ADDR_W:0]   wr_addr;
  logic [7:0]        rd_data;
  logic [7:0]        csum_d;

  assign fire    = tx_valid_q && tx.tx_ready;
  assign wr_en   = sample_valid && !bank_full_q[wr_bank_q];
  assign wr_addr = {wr_bank_q, wr_idx_q};
  assign csum_d  = checksum_q ^ tx_byte_q;

  // The RAM read has one cycle of latency, so when a data byte is consumed the
  // address already moves to the following one to keep the stream bubble-free.
  assign ld_data  = fire && ((state_q == ST_CNT) || ((state_q == ST_DATA) && !rd_last_q));
  assign rd_idx_d = ld_data ? rd_idx_q + ADDR_W'(1) : rd_idx_q;
  assign rd_addr  = {rd_bank_q, rd_idx_d};

  frame_buf_ram #(
    .DEPTH (2 * BUF_LEN),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (sample_in),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q   <= '0;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      state_q       <= ST_IDLE;
      rd_bank_q     <= 1'b0;
      rd_idx_q      <= '0;
      rd_last_q     <= 1'b0;
      checksum_q    <= '0;
      tx_byte_q     <= '0;
      tx_valid_q    <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (!bank_full_q[wr_bank_q]) begin
          wr_idx_q <= wr_idx_q + ADDR_W'(1);
          if (&wr_idx_q) begin
            bank_full_q[wr_bank_q] <= 1'b1;
            wr_bank_q              <= ~wr_bank_q;
          end
        end else begin
          overrun_q <= 1'b1;
        end
      end

      rd_idx_q <= rd_idx_d;

      // rd_bank_q always points at the oldest pending bank, since fills and sends alternate.
      case (state_q)
        ST_IDLE: begin
          if (bank_full_q[rd_bank_q]) begin
            state_q    <= ST_HDR;
            tx_valid_q <= 1'b1;
            tx_byte_q  <= SYNC_BYTE;
            checksum_q <= '0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (fire) begin
            state_q   <= ST_CNT;
            tx_byte_q <= frame_count_q;
          end
        end
        ST_CNT: begin
          if (fire) begin
            state_q    <= ST_DATA;
            checksum_q <= csum_d;
            tx_byte_q  <= rd_data;
            rd_last_q  <= &rd_idx_q;
          end
        end
        ST_DATA: begin
          if (fire) begin
            checksum_q <= csum_d;
            if (rd_last_q) begin
              state_q   <= ST_SUM;
              tx_byte_q <= csum_d;
            end else begin
              tx_byte_q <= rd_data;
              rd_last_q <= &rd_idx_q;
            end
          end
        end
        ST_SUM: begin
          if (fire) begin
            frame_count_q          <= frame_count_q + 8'd1;
            bank_full_q[rd_bank_q] <= 1'b0;
            rd_bank_q              <= ~rd_bank_q;
            rd_idx_q               <= '0;
            rd_last_q              <= 1'b0;
            checksum_q             <= '0;
            if (bank_full_q[~rd_bank_q]) begin
              state_q   <= ST_HDR;
              tx_byte_q <= SYNC_BYTE;
            end else begin
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_byte  = tx_byte_q;
  assign tx.tx_valid = tx_valid_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_frame_tx.sv
// Bench for audio_frame_tx with BUF_LEN=4: directed frames plus random traffic against a frame-level model.
module tb_audio_frame_tx;
  import audio_frame_pkg::*;

  localparam int BUF_LEN   = 4;
  localparam int FRAME_LEN = BUF_LEN + FRAME_OVERHEAD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] frame_count;
  logic       overrun;

  audio_frame_tx_if tx_if ();
  assign tx_if.tx_ready = tx_ready;

  audio_frame_tx #(.BUF_LEN(BUF_LEN), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .tx           (tx_if),
    .frame_count  (frame_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Frame-level reference: pending full frames, partial capture, expected byte stream.
  logic [7:0] exp_q[$];
  logic [7:0] cur_q[$];
  logic [7:0] log_q[$];
  int  pending = 0;
  int  in_frame = 0;
  int  sent = 0;
  int  filled = 0;
  bit  m_overrun = 0;
  bit  prev_stall = 0;
  bit  after_rst = 0;
  logic [7:0] prev_byte = '0;

  task automatic build_frame();
    logic [7:0] sum;
    sum = 8'(filled);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(filled));
    foreach (cur_q[k]) begin
      exp_q.push_back(cur_q[k]);
      sum = sum ^ cur_q[k];
    end
    exp_q.push_back(sum);
    cur_q.delete();
    filled++;
    pending++;
  endtask

  always @(negedge clk) begin
    bit rel;
    logic [8:0] want;
    if (rst) begin
      exp_q.delete(); cur_q.delete();
      pending = 0; in_frame = 0; sent = 0; filled = 0;
      m_overrun = 0; prev_stall = 0; after_rst = 1;
    end else begin
      check_val("frame_count", frame_count, 32'(sent % 256));
      check_val("overrun", overrun, m_overrun);
      if (after_rst) begin
        check_val("post_rst_valid", tx_if.tx_valid, 0);
        check_val("post_rst_byte", tx_if.tx_byte, 0);
        after_rst = 0;
      end
      if (prev_stall) begin
        check_val("stall_valid", tx_if.tx_valid, 1);
        check_val("stall_byte", tx_if.tx_byte, prev_byte);
      end
      if (in_frame != 0) check_val("no_gap", tx_if.tx_valid, 1);
      rel = 0;
      if (tx_if.tx_valid && tx_ready) begin
        log_q.push_back(tx_if.tx_byte);
        want = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check_val("tx_byte", {23'd0, 1'b0, tx_if.tx_byte}, {23'd0, want});
        in_frame++;
        if (in_frame == FRAME_LEN) begin
          in_frame = 0;
          sent++;
          rel = 1;
        end
      end
      prev_stall = tx_if.tx_valid && !tx_ready;
      prev_byte  = tx_if.tx_byte;
      if (sample_valid) begin
        if (pending == 2) m_overrun = 1;
        else begin
          cur_q.push_back(sample_in);
          if (cur_q.size() == BUF_LEN) build_frame();
        end
      end
      if (rel) pending--;
    end
  end

  // tx_ready pattern: 0 hold, 1 toggle, 2 random
  int   ready_mode = 0;
  logic ready_hold = 1'b1;
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: tx_ready = ready_hold;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1; sample_valid = 1'b0;
    repeat (cyc) tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_in = first + 8'(i);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_mode = 0; ready_hold = 1'b1;
    while ((exp_q.size() != 0 || in_frame != 0 || pending != 0) && n < 600) begin
      tick(); n++;
    end
    repeat (3) tick();
    check_val(tag, (n < 600), 1);
  endtask

  task automatic compare_log(input string tag, input logic [7:0] ref_q[$]);
    check_val({tag, "_len"}, log_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < log_q.size(); i++)
      check_val(tag, log_q[i], ref_q[i]);
  endtask

  initial begin
    logic [7:0] ref_q[$];
    int n;

    // reset state
    ready_mode = 0; ready_hold = 1'b1;
    do_reset(2);
    @(negedge clk);
    check_val("rst_tx_valid", tx_if.tx_valid, 0);
    check_val("rst_tx_byte", tx_if.tx_byte, 0);
    check_val("rst_frame_count", frame_count, 0);
    check_val("rst_overrun", overrun, 0);
    tick();

    // single frame, latency from last sample
    log_q.delete();
    send(8'h01, 3);
    sample_valid = 1'b1; sample_in = 8'h04;
    tick();
    sample_valid = 1'b0;
    @(negedge clk);
    check_val("lat_c1_valid", tx_if.tx_valid, 0);
    tick();
    @(negedge clk);
    check_val("lat_c2_valid", tx_if.tx_valid, 1);
    check_val("lat_c2_byte", tx_if.tx_byte, 8'hA5);
    drain("drain_t2");
    ref_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    compare_log("t2_bytes", ref_q);
    check_val("t2_frame_count", frame_count, 1);

    // toggling ready
    do_reset(1);
    log_q.delete();
    ready_mode = 1;
    send(8'h01, 4);
    n = 0;
    while (log_q.size() < FRAME_LEN && n < 100) begin tick(); n++; end
    check_val("t3_done", (n < 100), 1);
    drain("drain_t3");
    compare_log("t3_bytes", ref_q);

    // back-to-back frames
    do_reset(1);
    log_q.delete();
    send(8'h01, 8);
    drain("drain_t4");
    ref_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
              8'hA5, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D};
    compare_log("t4_bytes", ref_q);
    check_val("t4_frame_count", frame_count, 2);
    check_val("t4_overrun", overrun, 0);

    // overrun with stalled transmitter
    ready_hold = 1'b0;
    do_reset(1);
    log_q.delete();
    send(8'h01, 8);
    check_val("t5_no_overrun_8", overrun, 0);
    send(8'h09, 1);
    check_val("t5_overrun_9", overrun, 1);
    send(8'h0A, 3);
    drain("drain_t5");
    compare_log("t5_bytes", ref_q);
    check_val("t5_overrun_sticky", overrun, 1);

    // reset mid-frame
    do_reset(1);
    log_q.delete();
    send(8'h20, 4);
    n = 0;
    while (log_q.size() < 3 && n < 50) begin tick(); n++; end
    check_val("t6_three_tx", log_q.size(), 3);
    do_reset(1);
    @(negedge clk);
    check_val("t6_valid_low", tx_if.tx_valid, 0);
    tick();
    log_q.delete();
    send(8'h10, 4);
    drain("drain_t6");
    ref_q = '{8'hA5, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
    compare_log("t6_bytes", ref_q);

    // random traffic against the model
    do_reset(1);
    ready_mode = 2;
    for (int i = 0; i < 600; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_in = 8'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    drain("drain_rand");
    check_val("rand_frames", frame_count, 32'(sent % 256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
